// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver and its entry FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_ENTRY_W    = 10;

  // Eight data bits plus the parity bit must carry odd weight.
  function automatic logic odd_weight(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO holding decoded {ext, brk, scan} entries.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: synchronise, frame, fold E0/F0 prefixes into flags,
// and queue the resulting entries for the host.
module ps2_scan_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [PS2_ENTRY_W-1:0]   code_out,
  output logic                     code_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fall;

  ps2_state_e state, state_nx;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_ok;
  logic [TW-1:0] to_cnt;
  logic        to_hit, frame_done, good, bad;
  logic        is_ext, is_brk, push, drop;
  logic        ext_pend, brk_pend;
  logic        fifo_full, fifo_empty;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // A falling edge in the same cycle restarts the timeout, so it cannot also abort.
  assign to_hit = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    if (to_hit) begin
      state_nx = ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE:   if (!dat_s) state_nx = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        ST_PARITY: state_nx = ST_STOP;
        ST_STOP: begin
          state_nx   = ST_IDLE;
          frame_done = 1'b1;
        end
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  assign good   = frame_done & par_ok & dat_s;
  assign bad    = (frame_done & ~(par_ok & dat_s)) | to_hit;
  assign is_ext = (shreg == PS2_EXT_PREFIX);
  assign is_brk = (shreg == PS2_BRK_PREFIX);
  assign push   = good & ~is_ext & ~is_brk;
  assign drop   = push & fifo_full & ~rd_en;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      to_cnt <= (state == ST_IDLE || fall || to_hit) ? '0 : to_cnt + TW'(1);
      if (fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_ok <= odd_weight({shreg, dat_s});
          default:   ;
        endcase
      end
      if (bad) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (good) begin
        if (is_ext)      ext_pend <= 1'b1;
        else if (is_brk) brk_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (bad)          frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  ps2_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PS2_ENTRY_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .push  (push),
    .pop   (rd_en),
    .wdata ({ext_pend, brk_pend, shreg}),
    .rdata (code_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign code_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed bench for ps2_scan_fifo: frame-level model with an entry queue,
// compared against the outputs every cycle outside frame-completion windows.
module tb_ps2_scan_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int TMO   = 300;
  localparam int HALF  = 8;

  logic       CLOCK_50 = 1'b0;
  logic       resetn, ps2_clk, ps2_dat, rd_en, clr_err;
  logic [9:0] code_out;
  logic       code_valid;
  logic [3:0] count;
  logic       overflow, frame_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_scan_fifo #(
    .DEPTH          (DEPTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .code_out   (code_out),
    .code_valid (code_valid),
    .count      (count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int errors = 0;
  bit settle;
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ovf, m_ferr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLOCK_50) begin
    #1;
    if (!settle) begin
      chk("code_valid", 32'(code_valid), 32'(q.size() != 0));
      chk("count", 32'(count), 32'(q.size()));
      chk("code_out", 32'(code_out), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (q.size() < DEPTH) q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Bits go out LSB first: start, 8 data, parity, stop.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      cyc(HALF);
      if (i == 10) settle = 1;
      ps2_clk = 0;
      if (i == 10 && pop_at_stop) begin
        cyc(SYNC);
        rd_en = 1;
        cyc(1);
        rd_en = 0;
        cyc(HALF - SYNC - 1);
      end else cyc(HALF);
      ps2_clk = 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_at_stop);
    logic p;
    p = (~^b) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11, pop_at_stop);
    cyc(HALF);
    if (pop_at_stop && q.size() != 0) void'(q.pop_front());
    model_frame(b, !bad_par && !bad_stop);
    settle = 0;
    cyc(HALF);
  endtask

  task automatic good_frame(input logic [7:0] b);
    send_frame(b, 0, 0, 0);
  endtask

  task automatic pop_exp(input logic [9:0] exp, input string name);
    chk(name, 32'(code_out), 32'(exp));
    rd_en = 1;
    if (q.size() != 0) void'(q.pop_front());
    cyc(1);
    rd_en = 0;
  endtask

  task automatic clear_err();
    clr_err = 1;
    m_ovf = 0; m_ferr = 0;
    cyc(1);
    clr_err = 0;
  endtask

  initial begin
    resetn = 0; ps2_clk = 1; ps2_dat = 1; rd_en = 0; clr_err = 0; settle = 0;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
    cyc(3);
    chk("rst_valid", 32'(code_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_code", 32'(code_out), 0);
    chk("rst_errs", 32'({overflow, frame_err}), 0);
    resetn = 1;
    cyc(4);

    // Plain make code.
    good_frame(8'h1C);
    chk("single_code", 32'(code_out), 32'h01C);
    chk("single_count", 32'(count), 1);
    chk("single_errs", 32'({overflow, frame_err}), 0);
    pop_exp(10'h01C, "single_pop");
    cyc(1);

    // Extended break: prefixes fold into one entry.
    good_frame(8'hE0);
    good_frame(8'hF0);
    chk("prefix_count", 32'(count), 0);
    good_frame(8'h75);
    chk("extbrk_count", 32'(count), 1);
    chk("extbrk_code", 32'(code_out), 32'h375);
    pop_exp(10'h375, "extbrk_pop");
    cyc(1);
    chk("extbrk_empty", 32'(code_valid), 0);

    // Parity error, then clear.
    send_frame(8'h1C, 1, 0, 0);
    chk("par_ferr", 32'(frame_err), 1);
    chk("par_count", 32'(count), 0);
    clear_err();
    cyc(1);
    chk("par_clr", 32'(frame_err), 0);

    // Stop-bit error flushes a pending prefix.
    good_frame(8'hE0);
    send_frame(8'h22, 0, 1, 0);
    chk("stop_ferr", 32'(frame_err), 1);
    clear_err();
    good_frame(8'h11);
    chk("flush_code", 32'(code_out), 32'h011);
    pop_exp(10'h011, "flush_pop");
    cyc(1);

    // Overflow: DEPTH+1 frames without reads.
    for (int i = 1; i <= DEPTH + 1; i++) good_frame(8'(i));
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    clear_err();
    cyc(1);
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 1; i <= DEPTH; i++) pop_exp(10'(i), "ovf_pop");
    cyc(1);
    chk("drain_count", 32'(count), 0);
    rd_en = 1;
    cyc(2);
    rd_en = 0;
    cyc(1);
    chk("empty_pop_count", 32'(count), 0);
    chk("empty_pop_valid", 32'(code_valid), 0);

    // Timeout mid-frame also drops a pending prefix.
    good_frame(8'hE0);
    send_bits({2'b11, 8'h29, 1'b0}, 4, 0);
    settle = 1;
    cyc(TMO + 20);
    m_ferr = 1; m_ext = 0; m_brk = 0;
    chk("tmo_ferr", 32'(frame_err), 1);
    chk("tmo_count", 32'(count), 0);
    settle = 0;
    clear_err();
    good_frame(8'h29);
    chk("tmo_next_code", 32'(code_out), 32'h029);
    pop_exp(10'h029, "tmo_pop");
    cyc(1);

    // Full FIFO, pop coincident with the push.
    for (int i = 1; i <= DEPTH; i++) good_frame(8'(8'h30 + i));
    chk("full_count", 32'(count), 8);
    send_frame(8'h5A, 0, 0, 1);
    chk("pushpop_count", 32'(count), 8);
    chk("pushpop_ovf", 32'(overflow), 0);
    for (int i = 2; i <= DEPTH; i++) pop_exp(10'(8'h30 + i), "pushpop_pop");
    pop_exp(10'h05A, "pushpop_last");
    cyc(1);

    // Reset mid-frame with an entry stored.
    good_frame(8'h10);
    send_bits({2'b11, 8'h44, 1'b0}, 5, 0);
    resetn = 0;
    q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_ferr = 0;
    cyc(1);
    chk("midrst_code", 32'(code_out), 0);
    chk("midrst_valid", 32'(code_valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_errs", 32'({overflow, frame_err}), 0);
    cyc(2);
    resetn = 1;
    cyc(4);
    good_frame(8'h44);
    chk("post_rst_code", 32'(code_out), 32'h044);
    chk("post_rst_count", 32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_fifo.md
PS2_SCAN_FIFO -- requirements
Module: ps2_scan_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk and ps2_dat; minimum 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, idle CLOCK_50 cycles between ps2_clk falling edges that abort a frame (1 ms at 50 MHz).
REQ-004 CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 ps2_clk  in  1  raw PS/2 clock, asynchronous to CLOCK_50.
REQ-007 ps2_dat  in  1  raw PS/2 data, asynchronous to CLOCK_50.
REQ-008 rd_en  in  1  pop request for the head entry.
REQ-009 clr_err  in  1  clears the sticky error flags.
REQ-010 code_out  out  10  head entry {ext, brk, scan[7:0]}; first-word fall-through.
REQ-011 code_valid  out  1  FIFO not empty.
REQ-012 count  out  $clog2(DEPTH)+1  number of stored entries.
REQ-013 overflow  out  1  sticky: a decoded entry was dropped because the FIFO was full.
REQ-014 frame_err  out  1  sticky: parity, stop-bit or timeout failure.

Function
REQ-015 Both PS/2 inputs pass through SYNC_STAGES flops; a falling edge is a synchronised 1 followed by a synchronised 0, flagged for exactly one cycle.
REQ-016 Receiver FSM states: IDLE, DATA, PARITY, STOP; ps2_dat is sampled only on falling-edge cycles.
REQ-017 IDLE: edge with dat=0 -> DATA, bit counter cleared; edge with dat=1 -> stay IDLE.
REQ-018 DATA: shift dat in LSB-first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture bit -> STOP; frame good only if data bits plus parity bit have odd weight.
REQ-020 STOP: capture bit -> IDLE; frame good only if stop=1 and parity good.
REQ-021 A timeout counter runs outside IDLE, resets on every falling edge; reaching TIMEOUT_CYCLES -> IDLE and sets frame_err.
REQ-022 Good byte 0xE0 sets ext_pend; good byte 0xF0 sets brk_pend; neither is pushed.
REQ-023 Any other good byte pushes {ext_pend, brk_pend, byte} in the STOP-edge cycle, then clears both pending flags.
REQ-024 Bad frame or timeout: byte discarded, ext_pend and brk_pend cleared, frame_err set.
REQ-025 Push when full and no pop in the same cycle: entry dropped, overflow set, contents unchanged.
REQ-026 Push and pop in the same cycle: both performed, count unchanged; legal when full.
REQ-027 rd_en with code_valid=0 is ignored; no pointer or count change.
REQ-028 Push latency: code_valid and count update on the cycle after the push cycle.
REQ-029 Pointers wrap modulo DEPTH; count never exceeds DEPTH and never underflows.
REQ-030 clr_err clears overflow and frame_err next cycle; a same-cycle set event takes priority over clear.

Reset
REQ-031 resetn low asynchronously forces FSM=IDLE, pointers, count, timeout, shift register, ext_pend, brk_pend, overflow and frame_err to 0; synchronisers to 1.
REQ-032 Under reset, code_out=0, code_valid=0, count=0.
REQ-033 Reset mid-frame discards the partial frame; reception resumes at the next start bit after release.

Structure
REQ-034 Shared package ps2_pkg holds the FSM state enum, PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0 and the entry-width constant.
REQ-035 Storage is a sub-module ps2_sync_fifo (DEPTH, width 10) with push/pop/full/empty/count; framing and prefix decode stay in ps2_scan_fifo.

Verification
REQ-036 Frame 0x1C, odd parity 0, stop 1 -> one entry code_out=10'h01C, count=1, errors 0.
REQ-037 Frames E0, F0, 75 -> exactly one entry 10'h375; pops to empty; code_valid=0.
REQ-038 Frame 0x1C with parity 1 -> frame_err=1, count=0; clr_err -> frame_err=0.
REQ-039 DEPTH+1 frames 0x01..0x09, no reads (DEPTH=8) -> count=8, overflow=1, pops return 0x001..0x008 in order.
REQ-040 Four bits then TIMEOUT_CYCLES of silence -> frame_err=1, FSM=IDLE; next frame 0x29 -> entry 10'h029.
REQ-041 FIFO full, rd_en held while a frame 0x5A completes -> count stays 8, 0x05A last in order; resetn low mid-frame -> all outputs 0.
